// File: rtl/relu_ctrl_pkg.sv
// relu_ctrl shared types: FSM state encoding and FIFO depth.
// Optional feature macro used by relu_ctrl: RELU_CTRL_PERF_EN.
package relu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } relu_ctrl_state_e;

    localparam int RELU_CTRL_FIFO_DEPTH = 2;

endpackage

// File: rtl/relu_ctrl_relu_arr.sv
// relu_arr: combinational per-word ReLU over one row.
// With en_i low every word passes through untouched.
module relu_arr #(
    parameter int SYS_COL    = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] data_i [0:SYS_COL-1],
    output logic [DATA_WIDTH-1:0] data_o [0:SYS_COL-1]
);

    // Zero negative words when enabled, otherwise pass through.
    always_comb begin
        for (int i = 0; i < SYS_COL; i++) begin
            if (en_i && data_i[i][DATA_WIDTH-1]) begin
                data_o[i] = '0;
            end else begin
                data_o[i] = data_i[i];
            end
        end
    end

endmodule

// File: rtl/relu_ctrl.sv
// relu_ctrl: layer sequencer for the activation stage, 2-entry row FIFO.
// Define RELU_CTRL_PERF_EN to add the perf_stall_cnt port and counter.
module relu_ctrl
    import relu_ctrl_pkg::*;
#(
    parameter int SYS_COL    = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic                  cfg_relu_en,
    input  logic [ADDR_WIDTH:0]   cfg_rows,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data  [0:SYS_COL-1],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data [0:SYS_COL-1],
    output logic                  busy,
    output logic                  done
`ifdef RELU_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(RELU_CTRL_FIFO_DEPTH);
    localparam logic [PTR_W-1:0]    PTR_ONE  = 1;
    localparam logic [PTR_W:0]      CNT_ONE  = 1;
    localparam logic [PTR_W:0]      CNT_FULL = RELU_CTRL_FIFO_DEPTH;
    localparam logic [ADDR_WIDTH:0] ACC_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] EMIT_ONE = 1;

    relu_ctrl_state_e state_q, state_d;

    logic                  relu_en_q, relu_en_d;
    logic [ADDR_WIDTH:0]   rows_q, rows_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   acc_q, acc_d;
    logic [ADDR_WIDTH-1:0] emit_q, emit_d;

    logic [DATA_WIDTH-1:0] mem_q [0:RELU_CTRL_FIFO_DEPTH-1][0:SYS_COL-1];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]        cnt_q;

    logic [DATA_WIDTH-1:0] act [0:SYS_COL-1];
    logic fifo_full, fifo_empty;
    logic push, pop, cfg_fire;

    relu_arr #(
        .SYS_COL   (SYS_COL),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_relu (
        .en_i  (relu_en_q),
        .data_i(in_data),
        .data_o(act)
    );

    assign fifo_full  = (cnt_q == CNT_FULL);
    assign fifo_empty = (cnt_q == '0);

    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign cfg_fire  = cfg_ready && cfg_valid;

    // in_ready looks only at FIFO occupancy, never at out_ready.
    assign in_ready = (state_q == RUN) && (acc_q < rows_q) && !fifo_full;
    assign push     = in_valid && in_ready;

    assign out_valid = !fifo_empty;
    assign out_data  = mem_q[rd_ptr_q];
    assign out_addr  = base_q + emit_q;
    assign pop       = out_valid && out_ready;

    // Next-state and layer bookkeeping.
    always_comb begin
        state_d   = state_q;
        relu_en_d = relu_en_q;
        rows_d    = rows_q;
        base_d    = base_q;
        acc_d     = acc_q;
        emit_d    = emit_q;
        if (push) begin
            acc_d = acc_q + ACC_ONE;
        end
        if (pop) begin
            emit_d = emit_q + EMIT_ONE;
        end
        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    relu_en_d = cfg_relu_en;
                    rows_d    = cfg_rows;
                    base_d    = cfg_base;
                    acc_d     = '0;
                    emit_d    = '0;
                    state_d   = (cfg_rows == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (push && (acc_q + ACC_ONE == rows_q)) begin
                    state_d = DRAIN;
                end
            end
            // Leave as the last row drains so done follows the final handshake.
            DRAIN: begin
                if (fifo_empty || (cnt_q == CNT_ONE && pop)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and latched layer configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            relu_en_q <= 1'b0;
            rows_q    <= '0;
            base_q    <= '0;
            acc_q     <= '0;
            emit_q    <= '0;
        end else begin
            state_q   <= state_d;
            relu_en_q <= relu_en_d;
            rows_q    <= rows_d;
            base_q    <= base_d;
            acc_q     <= acc_d;
            emit_q    <= emit_d;
        end
    end

    // Two-entry row FIFO; simultaneous push and pop keep occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int e = 0; e < RELU_CTRL_FIFO_DEPTH; e++) begin
                for (int w = 0; w < SYS_COL; w++) begin
                    mem_q[e][w] <= '0;
                end
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= act;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CNT_ONE;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

`ifdef RELU_CTRL_PERF_EN
    logic [31:0] stall_q;

    // Saturating count of cycles a row waits on the output buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (cfg_fire) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_q;
`else
    logic unused_cfg_fire;
    assign unused_cfg_fire = cfg_fire;
`endif

endmodule

// File: tb/tb_relu_ctrl.sv
// tb_relu_ctrl: scoreboard bench for relu_ctrl with a word-level model.
// Define RELU_CTRL_PERF_EN to also check perf_stall_cnt.
module tb_relu_ctrl;

    localparam int SC = 16;
    localparam int DW = 32;
    localparam int AW = 10;

    typedef logic [SC-1:0][DW-1:0] row_t;
    typedef struct {
        logic [AW-1:0] addr;
        row_t          data;
        bit            lat;
        int            acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_valid, cfg_ready, cfg_relu_en;
    logic [AW:0]   cfg_rows;
    logic [AW-1:0] cfg_base;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_data  [0:SC-1];
    logic          out_valid, out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data [0:SC-1];
    logic          busy, done;
`ifdef RELU_CTRL_PERF_EN
    logic [31:0]   perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    relu_ctrl #(.SYS_COL(SC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_relu_en(cfg_relu_en), .cfg_rows(cfg_rows), .cfg_base(cfg_base),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done)
`ifdef RELU_CTRL_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    int   w0_tab[$];
    int   rmode = 0;
    int   stall_start = 1 << 30;
    int   last_hs = 0;
    int   first_cyc = 0;
    int   done_total = 0;
    int   layers = 0;
    bit   head_seen = 0;
    bit   prev_stall = 0;
    row_t prev_d, cur;
    logic [AW-1:0] prev_a;
    exp_t me;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_row(input string nm, input row_t act, input row_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic row_t pack_out();
        row_t r;
        for (int i = 0; i < SC; i++) r[i] = out_data[i];
        return r;
    endfunction

    // Reference: negative words become zero when ReLU is on.
    function automatic row_t model(input bit en, input row_t r);
        row_t o;
        for (int i = 0; i < SC; i++)
            o[i] = (en && $signed(r[i]) < 0) ? '0 : r[i];
        return o;
    endfunction

    function automatic row_t mkrow(input int n);
        row_t r;
        for (int i = 0; i < SC; i++) r[i] = $urandom;
        if (n < w0_tab.size()) r[0] = 32'(w0_tab[n]);
        return r;
    endfunction

    task automatic drive_row(input row_t r);
        for (int i = 0; i < SC; i++) in_data[i] = r[i];
    endtask

    task automatic chk_reset_vals();
        row_t z;
        z = '0;
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_addr", out_addr, 0);
        chk_row("rst_out_data", pack_out(), z);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
`ifdef RELU_CTRL_PERF_EN
        chk("rst_perf", perf_stall_cnt, 0);
`endif
    endtask

    // out_ready pattern per test mode.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom % 2);
            2: out_ready = !(cyc >= stall_start && cyc < stall_start + 5);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            head_seen  = 0;
            prev_stall = 0;
        end else begin
            cur = pack_out();
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_addr", out_addr, prev_a);
                chk_row("hold_data", cur, prev_d);
            end
            if (out_valid && !head_seen) begin
                head_seen = 1;
                first_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: addr %0d with empty scoreboard", out_addr);
                end else begin
                    me = q.pop_front();
                    chk("out_addr", out_addr, me.addr);
                    chk_row("out_data", cur, me.data);
                    if (me.lat) chk("latency", first_cyc, me.acc + 1);
                end
                head_seen = 0;
                last_hs   = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = cur;
            prev_a     = out_addr;
            if (done) done_total++;
        end
    end

    task automatic run_layer(input bit en, input int rows, input int base,
                             input int mode, input bit lat, input bit gaps);
        int   n, guard, cfg_cyc, exp_done;
        row_t r;
        exp_t e;
        rmode = mode;
        stall_start = 1 << 30;
        @(posedge clk); #1;
        cfg_valid   = 1;
        cfg_relu_en = en;
        cfg_rows    = (AW+1)'(rows);
        cfg_base    = AW'(base);
        @(negedge clk);
        chk("cfg_ready", cfg_ready, 1);
        cfg_cyc = cyc;
        @(posedge clk); #1;
        cfg_valid = 0;
        n = 0;
        guard = 0;
        if (rows > 0) begin
            r = mkrow(0);
            drive_row(r);
            in_valid = !gaps || ($urandom % 3 != 0);
            while (n < rows && guard < 3000) begin
                @(negedge clk);
                guard++;
                if (in_valid && in_ready) begin
                    e.addr = AW'((base + n) % (1 << AW));
                    e.data = model(en, r);
                    e.lat  = lat;
                    e.acc  = cyc;
                    q.push_back(e);
                    if (n == 0 && mode == 2) stall_start = cyc + 1;
                    n++;
                end
                if (mode == 2 && cyc == stall_start + 4) begin
                    chk("stall_accepts", n, 2);
                    chk("stall_in_ready", in_ready, 0);
                end
                @(posedge clk); #1;
                if (n < rows) begin
                    r = mkrow(n);
                    drive_row(r);
                    in_valid = !gaps || ($urandom % 3 != 0);
                end else begin
                    in_valid = 0;
                end
                if (gaps) begin
                    cfg_valid = 1'($urandom % 2);
                    cfg_rows  = (AW+1)'($urandom);
                    cfg_base  = AW'($urandom);
                end
            end
            if (n < rows) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got %0d rows expected %0d", n, rows);
            end
        end
        cfg_valid = 0;
        in_valid  = 0;
        guard = 0;
        do begin
            @(negedge clk); #1;
            guard++;
            chk("drain_in_ready", in_ready, 0);
            chk("drain_busy", busy, 1);
        end while (!done && guard < 500);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected one within %0d cycles", guard);
        end else begin
            layers++;
            exp_done = (rows == 0) ? cfg_cyc + 1 : last_hs + 1;
            chk("done_cycle", cyc, exp_done);
        end
        @(negedge clk); #1;
        chk("done_pulse_len", done, 0);
        chk("busy_after_done", busy, 0);
        chk("cfg_ready_after", cfg_ready, 1);
        chk("scoreboard_empty", q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, guard, done_before;
        rst_n = 0;
        cfg_valid = 0; cfg_relu_en = 0; cfg_rows = '0; cfg_base = '0;
        in_valid = 0;
        for (int i = 0; i < SC; i++) in_data[i] = '0;
        out_ready = 0;
        #12;
        chk_reset_vals();
        #10 rst_n = 1;

        w0_tab = '{-7, 12, 0};
        run_layer(1, 3, 5, 0, 1, 0);
        run_layer(0, 3, 5, 0, 1, 0);
        w0_tab = '{};

        run_layer(1'($urandom % 2), 4, 40, 2, 0, 0);
`ifdef RELU_CTRL_PERF_EN
        chk("perf_stall_cnt", perf_stall_cnt, 5);
`endif

        run_layer(1, 0, 77, 0, 0, 0);
        run_layer(1, 4, 1022, 0, 1, 0);

        for (int k = 0; k < 25; k++)
            run_layer(1'($urandom % 2), $urandom_range(1, 9), $urandom_range(0, 1023), 1, 0, 1);

        // Reset in the middle of a 5-row layer after two accepts.
        done_before = done_total;
        rmode = 3;
        @(posedge clk); #1;
        cfg_valid = 1; cfg_relu_en = 1; cfg_rows = 5; cfg_base = 100;
        @(posedge clk); #1;
        cfg_valid = 0;
        drive_row(mkrow(0));
        in_valid = 1;
        n = 0;
        guard = 0;
        while (n < 2 && guard < 50) begin
            @(negedge clk);
            guard++;
            if (in_ready) n++;
            @(posedge clk); #1;
            drive_row(mkrow(n));
        end
        chk("rst_test_accepts", n, 2);
        in_valid = 0;
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        chk_reset_vals();
        q.delete();
        @(posedge clk); #3;
        rst_n = 1;
        rmode = 0;
        @(negedge clk);
        chk("post_rst_cfg_ready", cfg_ready, 1);
        repeat (4) @(negedge clk);
        chk("no_done_on_reset", done_total, done_before);
        chk("done_count", done_total, layers);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
